// File: rtl/mdu_param.sv
// Parametrised multiply/divide unit with HI/LO, multiply-accumulate, flush and done pulse.
// The full result is computed at accept; the counter only models pipeline latency.
module mdu_param #(
   parameter int WIDTH      = 32,
   parameter int MUL_CYCLES = 5,
   parameter int DIV_CYCLES = 10
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             valid,
   input  logic [3:0]       op,
   input  logic             flush,
   input  logic [WIDTH-1:0] operand1,
   input  logic [WIDTH-1:0] operand2,
   output logic             start,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam logic [3:0] OP_MULT  = 4'd1;
   localparam logic [3:0] OP_MULTU = 4'd2;
   localparam logic [3:0] OP_DIV   = 4'd3;
   localparam logic [3:0] OP_DIVU  = 4'd4;
   localparam logic [3:0] OP_MTHI  = 4'd5;
   localparam logic [3:0] OP_MTLO  = 4'd6;
   localparam logic [3:0] OP_MADD  = 4'd7;
   localparam logic [3:0] OP_MADDU = 4'd8;
   localparam logic [3:0] OP_MSUB  = 4'd9;
   localparam logic [3:0] OP_MSUBU = 4'd10;

   localparam int MAX_CYCLES = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
   localparam int CNT_W      = $clog2(MAX_CYCLES + 1);
   localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

   typedef enum logic {IDLE, RUN} state_t;

   state_t                 state, state_next;
   logic [CNT_W-1:0]       counter;
   logic [WIDTH-1:0]       pend_hi, pend_lo;
   logic                   pend_write;
   logic                   is_multi, is_div, idle_ok, expire;

   logic [2*WIDTH-1:0]     a_ext_s, b_ext_s, a_ext_u, b_ext_u;
   logic [2*WIDTH-1:0]     prod_s, prod_u, acc;
   logic [2*WIDTH-1:0]     res_next;
   logic                   write_next;
   logic                   div_ovf;
   logic [WIDTH-1:0]       divisor_s, divisor_u;
   logic [WIDTH-1:0]       quo_s, rem_s, quo_u, rem_u;

   always_comb begin
      is_multi = 1'b0;
      case (op)
         OP_MULT, OP_MULTU, OP_DIV, OP_DIVU,
         OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU: is_multi = 1'b1;
         default:                              is_multi = 1'b0;
      endcase
   end

   assign is_div  = (op == OP_DIV) || (op == OP_DIVU);
   assign idle_ok = valid && !flush && (state == IDLE);
   assign start   = idle_ok && is_multi;
   assign expire  = (counter == CNT_W'(1));

   assign a_ext_s = {{WIDTH{operand1[WIDTH-1]}}, operand1};
   assign b_ext_s = {{WIDTH{operand2[WIDTH-1]}}, operand2};
   assign a_ext_u = {{WIDTH{1'b0}}, operand1};
   assign b_ext_u = {{WIDTH{1'b0}}, operand2};
   assign prod_s  = a_ext_s * b_ext_s;
   assign prod_u  = a_ext_u * b_ext_u;
   assign acc     = {hi, lo};

   // Zero divisors and MIN/-1 are steered to a divide by one: MIN/1 already yields the
   // required MIN quotient and zero remainder, and the simulator never sees an overflow.
   assign div_ovf   = (operand1 == MIN_VAL) && (operand2 == {WIDTH{1'b1}});
   assign divisor_s = ((operand2 == '0) || div_ovf) ? WIDTH'(1) : operand2;
   assign divisor_u = (operand2 == '0) ? WIDTH'(1) : operand2;
   assign quo_s     = $signed(operand1) / $signed(divisor_s);
   assign rem_s     = $signed(operand1) % $signed(divisor_s);
   assign quo_u     = operand1 / divisor_u;
   assign rem_u     = operand1 % divisor_u;

   always_comb begin
      res_next   = '0;
      write_next = 1'b1;
      case (op)
         OP_MULT:  res_next = prod_s;
         OP_MULTU: res_next = prod_u;
         OP_DIV:   begin res_next = {rem_s, quo_s}; write_next = (operand2 != '0); end
         OP_DIVU:  begin res_next = {rem_u, quo_u}; write_next = (operand2 != '0); end
         OP_MADD:  res_next = acc + prod_s;
         OP_MADDU: res_next = acc + prod_u;
         OP_MSUB:  res_next = acc - prod_s;
         OP_MSUBU: res_next = acc - prod_u;
         default:  write_next = 1'b0;
      endcase
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (start) state_next = RUN;
         RUN:     if (flush || expire) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         counter    <= '0;
         busy       <= 1'b0;
         done       <= 1'b0;
         hi         <= '0;
         lo         <= '0;
         pend_hi    <= '0;
         pend_lo    <= '0;
         pend_write <= 1'b0;
      end else begin
         state <= state_next;
         done  <= 1'b0;
         if (start) begin
            counter    <= is_div ? CNT_W'(DIV_CYCLES) : CNT_W'(MUL_CYCLES);
            busy       <= 1'b1;
            pend_hi    <= res_next[2*WIDTH-1:WIDTH];
            pend_lo    <= res_next[WIDTH-1:0];
            pend_write <= write_next;
         end else if (state == RUN) begin
            counter <= counter - CNT_W'(1);
            if (flush) begin
               busy    <= 1'b0;
               counter <= '0;
            end else if (expire) begin
               busy <= 1'b0;
               done <= 1'b1;
               if (pend_write) begin
                  hi <= pend_hi;
                  lo <= pend_lo;
               end
            end
         end else if (idle_ok) begin
            if (op == OP_MTHI) hi <= operand1;
            if (op == OP_MTLO) lo <= operand1;
         end
      end
   end

endmodule

// File: doc/mdu_param.md
Name: mdu_param

Overview:
- Parametrised multiply/divide unit for the E stage; successor to the fixed-latency MDU.
- Adds configurable width and latencies, multiply-accumulate ops (madd/maddu/msub/msubu), a flush/cancel input and a done pulse.
- The hazard unit stalls D while start || busy and a HI/LO-touching instruction sits in D.
- HI/LO are architectural registers held inside this block.

Parameters:
- WIDTH, 32, operand and HI/LO width; must be even and at least 8.
- MUL_CYCLES, 5, busy cycles for mult/multu/madd/maddu/msub/msubu; must be at least 1.
- DIV_CYCLES, 10, busy cycles for div/divu; must be at least 1.

Ports:
- clk  in  1  system clock; one clock domain, all state updates on its rising edge.
- reset  in  1  synchronous, active-high reset.
- valid  in  1  an op is presented this cycle.
- op  in  4  operation code; 0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 MADD, 8 MADDU, 9 MSUB, 10 MSUBU; 11-15 behave as NONE.
- flush  in  1  cancel any in-flight op and any op presented this cycle.
- operand1  in  WIDTH  rs value; multiplicand, dividend, or the MTHI/MTLO source.
- operand2  in  WIDTH  rt value; multiplier or divisor.
- start  out  1  combinational; a multi-cycle op is accepted this cycle.
- busy  out  1  registered; a multi-cycle op is in progress.
- done  out  1  registered; one-cycle pulse, the cycle after HI/LO commit.
- hi  out  WIDTH  HI register, registered.
- lo  out  WIDTH  LO register, registered.

Behaviour:
- Reset: priority over all other inputs. hi=0, lo=0, busy=0, done=0, counter=0, state IDLE, pending result discarded.
- States:
  - IDLE -> RUN on accept.
  - RUN -> IDLE when the counter expires or on flush.
- Accept: start = valid && !flush && state==IDLE && op is in {1,2,3,4,7,8,9,10}.
- On the accept edge:
  - Operands are latched.
  - The full result is computed into pending registers.
  - The counter is loaded with MUL_CYCLES or DIV_CYCLES.
- Timing for an op accepted in cycle T with latency L:
  - busy=1 in cycles T+1..T+L.
  - HI/LO are written on the edge ending cycle T+L.
  - busy=0 and done=1 in cycle T+L+1.
  - Issue-to-issue spacing is therefore L+1.
- MTHI/MTLO:
  - Take effect when valid && !flush && state==IDLE.
  - hi (or lo) takes operand1 on the next edge.
  - No busy, no start, no done.
- Ops presented while RUN are ignored entirely, with no state change; upstream must stall.
- MULT/MULTU: {hi,lo} = 2*WIDTH-bit signed/unsigned product.
- DIV/DIVU:
  - lo = quotient, truncated toward zero.
  - hi = remainder, with the sign of the dividend.
  - Divisor 0: full DIV_CYCLES busy, hi/lo unchanged at commit, done still pulses.
  - Signed MIN/-1: lo = MIN, hi = 0.
- MADD(U)/MSUB(U):
  - {hi,lo} = {hi,lo} +/- product, modulo 2^(2*WIDTH).
  - Signed or unsigned product as named.
  - The accumulator base is the hi/lo value at accept; it cannot change while busy.
- Flush:
  - During RUN: state becomes IDLE next edge, busy=0 next cycle, no commit, no done, hi/lo unchanged.
  - Flush in the expiry cycle (T+L) also suppresses the commit.
  - Flush in the same cycle as valid suppresses the start and any MTHI/MTLO write.
- Reset mid-operation aborts the op and applies the reset values above.
- hi/lo change only on a commit edge, an MTHI/MTLO edge, or reset.

Test Plan:
- Reset, then MULT with 0xFFFFFFFF, 0x00000002 at cycle T:
  - start=1 in T.
  - busy=1 in T+1..T+5.
  - done=1 in T+6.
  - hi=0xFFFFFFFF, lo=0xFFFFFFFE.
  - Repeat as MULTU: hi=0x00000001, lo=0xFFFFFFFE.
- DIV with 0xFFFFFFF9 (-7), 0x00000002 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF after 10 busy cycles.
  - DIVU 7/0 -> busy 10 cycles, hi/lo unchanged, done pulses.
  - DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
- MTHI 0, then MTLO 0xFFFFFFFF (each visible the next cycle, busy stays 0).
  - Then MADDU 1*1 -> hi=1, lo=0.
  - Then MSUB 1*1 -> hi=0, lo=0xFFFFFFFF.
- DIVU 100/3, flush asserted in the 3rd busy cycle:
  - busy=0 the next cycle.
  - done never pulses.
  - hi/lo keep their prior values.
  - A new MULT issued right after completes normally.
- MULT accepted, MTLO and a second MULT presented while busy -> both ignored; only the first result commits.
- Reset asserted mid-MULT -> next cycle hi=lo=0, busy=0, done=0.
- valid && flush with MTHI 0x1234 -> hi unchanged, start=0.
